snake_judge: RTL and testbench

Per-step rules engine downstream of the snake position calculator. After each position update it scans the packed coordinate array against the head, the field walls and the food cell. It emits a one-cycle `grow` pulse when food is eaten, and `game_over` on a wall or self collision. It also places new food on a free cell using an LFSR, and feeds `grow` back to the calculator and food coordinates to the renderer.

---
 rtl/snake_pkg.sv | 40 ++++
 rtl/snake_lfsr16.sv | 35 +++
 rtl/snake_judge.sv | 211 +++++++++++++++++++++
 tb/tb_snake_judge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared types, widths and helpers for the snake rules engine.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int COORD_W = 8;
  localparam int SEG_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALL   = 3'd1,
    SCAN   = 3'd2,
    PLACE  = 3'd3,
    VERIFY = 3'd4,
    FIN    = 3'd5
  } state_t;

  function automatic int seg_x(input int i);
    return i * SEG_W;
  endfunction

  function automatic int seg_y(input int i);
    return i * SEG_W + COORD_W;
  endfunction

  // Smallest all-ones value m with m+1 >= size (2^ceil(log2 size) - 1).
  function automatic int coord_mask(input int size);
    int m;
    m = 0;
    for (int b = 0; b < COORD_W; b++) begin
      if (m + 1 < size) m = m * 2 + 1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : snake_lfsr16
// Purpose  : 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, load wins.
// Revision : 1.0 - initial release
// ============================================================================
module snake_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign q    = r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (load) begin
      r_lfsr <= seed;
    end else if (en) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_judge.sv
`default_nettype none
// ============================================================================
// Module   : snake_judge
// Purpose  : Per-step wall/self/food judge with LFSR-driven food placement.
// Revision : 1.0 - initial release
// ============================================================================
module snake_judge
  import snake_pkg::*;
#(
  parameter int          SIZE_X = 10,
  parameter int          SIZE_Y = 10,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            check,
  input  logic [15:0]                     lengh,
  input  logic [SIZE_X*SIZE_Y*SEG_W-1:0]  snake_xy,
  output logic                            grow,
  output logic                            game_over,
  output logic                            win,
  output logic [COORD_W-1:0]              food_x,
  output logic [COORD_W-1:0]              food_y,
  output logic                            busy,
  output logic                            done
);

  localparam int                 c_CELLS = SIZE_X * SIZE_Y;
  localparam logic [COORD_W-1:0] c_XMASK = COORD_W'(coord_mask(SIZE_X));
  localparam logic [COORD_W-1:0] c_YMASK = COORD_W'(coord_mask(SIZE_Y));
  localparam logic [COORD_W-1:0] c_CX    = COORD_W'(SIZE_X / 2);
  localparam logic [COORD_W-1:0] c_CY    = COORD_W'(SIZE_Y / 2);

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_idx, w_idx_nxt;
  logic [COORD_W-1:0]   r_hx, r_hy, w_hx_nxt, w_hy_nxt;
  logic [COORD_W-1:0]   r_cx, r_cy, w_cx_nxt, w_cy_nxt;
  logic [COORD_W-1:0]   r_fx, r_fy, w_fx_nxt, w_fy_nxt;
  logic                 r_eat, w_eat_nxt;
  logic                 r_go, w_go_nxt;
  logic                 r_win, w_win_nxt;
  logic                 w_lfsr_en;
  logic [15:0]          w_lfsr;

  logic [15:0]          w_len;
  logic                 w_last, w_full, w_out, w_eat_now, w_hit, w_cand_ok;
  logic [SEG_W-1:0]     w_seg, w_ref;
  logic [COORD_W-1:0]   w_cand_x, w_cand_y;

  snake_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (w_lfsr_en),
    .load (start),
    .seed (SEED),
    .q    (w_lfsr)
  );

  assign w_len     = (lengh > 16'(c_CELLS)) ? 16'(c_CELLS) : lengh;
  assign w_last    = (17'(r_idx) + 17'd1) >= 17'(w_len);
  assign w_full    = (17'(lengh) + 17'd1) >= 17'(c_CELLS);
  assign w_out     = ({1'b0, r_hx} >= 9'(SIZE_X)) || ({1'b0, r_hy} >= 9'(SIZE_Y));
  assign w_eat_now = (r_hx == r_fx) && (r_hy == r_fy);
  assign w_cand_x  = w_lfsr[7:0]  & c_XMASK;
  assign w_cand_y  = w_lfsr[15:8] & c_YMASK;
  assign w_cand_ok = ({1'b0, w_cand_x} < 9'(SIZE_X)) && ({1'b0, w_cand_y} < 9'(SIZE_Y));

  // One segment mux and one comparator serve both the self scan and food verify.
  always_comb begin
    w_seg = '0;
    for (int i = 0; i < c_CELLS; i++) begin
      if (r_idx == 16'(i)) begin
        w_seg = {snake_xy[seg_y(i) +: COORD_W], snake_xy[seg_x(i) +: COORD_W]};
      end
    end
  end

  assign w_ref = (r_state == VERIFY) ? {r_cy, r_cx} : {r_hy, r_hx};
  assign w_hit = (w_seg == w_ref);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hx_nxt    = r_hx;
    w_hy_nxt    = r_hy;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_fx_nxt    = r_fx;
    w_fy_nxt    = r_fy;
    w_eat_nxt   = r_eat;
    w_go_nxt    = r_go;
    w_win_nxt   = r_win;
    w_lfsr_en   = 1'b0;

    case (r_state)
      IDLE: begin
        if (check && !r_go && !r_win) begin
          w_hx_nxt    = snake_xy[seg_x(0) +: COORD_W];
          w_hy_nxt    = snake_xy[seg_y(0) +: COORD_W];
          w_idx_nxt   = 16'd1;
          w_state_nxt = WALL;
        end
      end
      WALL: begin
        w_eat_nxt = w_eat_now;
        if (w_out) begin
          w_go_nxt    = 1'b1;
          w_state_nxt = FIN;
        end else if (w_len > 16'd1) begin
          w_state_nxt = SCAN;
        end else if (!w_eat_now) begin
          w_state_nxt = FIN;
        end else if (w_full) begin
          w_win_nxt   = 1'b1;
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = PLACE;
        end
      end
      SCAN: begin
        if (w_hit) begin
          w_go_nxt    = 1'b1;
          w_state_nxt = FIN;
        end else if (!w_last) begin
          w_idx_nxt = r_idx + 16'd1;
        end else if (!r_eat) begin
          w_state_nxt = FIN;
        end else if (w_full) begin
          // No free cell left for food: the snake has filled the field.
          w_win_nxt   = 1'b1;
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = PLACE;
        end
      end
      PLACE: begin
        w_lfsr_en = 1'b1;
        if (w_cand_ok) begin
          w_cx_nxt    = w_cand_x;
          w_cy_nxt    = w_cand_y;
          w_idx_nxt   = 16'd0;
          w_state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        if (w_hit && (w_len != 16'd0)) begin
          w_state_nxt = PLACE;
        end else if (!w_last) begin
          w_idx_nxt = r_idx + 16'd1;
        end else begin
          w_fx_nxt    = r_cx;
          w_fy_nxt    = r_cy;
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (start) begin
      w_state_nxt = IDLE;
      w_go_nxt    = 1'b0;
      w_win_nxt   = 1'b0;
      w_fx_nxt    = c_CX;
      w_fy_nxt    = c_CY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hx    <= '0;
      r_hy    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_fx    <= c_CX;
      r_fy    <= c_CY;
      r_eat   <= 1'b0;
      r_go    <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hx    <= w_hx_nxt;
      r_hy    <= w_hy_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_fx    <= w_fx_nxt;
      r_fy    <= w_fy_nxt;
      r_eat   <= w_eat_nxt;
      r_go    <= w_go_nxt;
      r_win   <= w_win_nxt;
    end
  end

  assign done      = (r_state == FIN);
  assign grow      = (r_state == FIN) && r_eat && !r_go;
  assign busy      = (r_state != IDLE);
  assign game_over = r_go;
  assign win       = r_win;
  assign food_x    = r_fx;
  assign food_y    = r_fy;

endmodule
`default_nettype wire

// File: tb/tb_snake_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_judge
// Purpose  : Directed self-checking bench for snake_judge on a 10x10 field.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_judge;

  localparam int c_SX    = 10;
  localparam int c_SY    = 10;
  localparam int c_CELLS = c_SX * c_SY;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  check;
  logic [15:0]           lengh;
  logic [c_CELLS*16-1:0] snake_xy;
  logic                  grow;
  logic                  game_over;
  logic                  win;
  logic [7:0]            food_x;
  logic [7:0]            food_y;
  logic                  busy;
  logic                  done;

  int n_checks = 0;
  int n_errors = 0;

  snake_judge #(.SIZE_X(c_SX), .SIZE_Y(c_SY), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .check     (check),
    .lengh     (lengh),
    .snake_xy  (snake_xy),
    .grow      (grow),
    .game_over (game_over),
    .win       (win),
    .food_x    (food_x),
    .food_y    (food_y),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic set_seg(input int i, input logic [7:0] x, input logic [7:0] y);
    snake_xy[i*16 +: 8]   = x;
    snake_xy[i*16+8 +: 8] = y;
  endtask

  // Pulses check and waits for done; lat counts cycles from check to done.
  task automatic run_step(output int lat, output logic g, output logic b_ok);
    check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    lat   = 1;
    b_ok  = 1'b1;
    while (!done && lat < 2000) begin
      if (!busy) b_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) b_ok = 1'b0;
    g = grow;
    chk_val("no_timeout", 32'(lat < 2000), 32'd1);
    @(negedge clk);
    chk_val("pulse_end", {29'd0, done, grow, busy}, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_ignored(input string tag);
    logic seen;
    seen  = 1'b0;
    check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    repeat (4) begin
      if (busy || done) seen = 1'b1;
      @(negedge clk);
    end
    chk_val(tag, 32'(seen), 32'd0);
  endtask

  task automatic snake3_eat();
    lengh = 16'd3;
    set_seg(0, 8'd5, 8'd5);
    set_seg(1, 8'd4, 8'd5);
    set_seg(2, 8'd3, 8'd5);
  endtask

  int   lat;
  logic g;
  logic b_ok;
  logic seen;
  logic free_ok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    check    = 1'b0;
    lengh    = 16'd0;
    snake_xy = '0;
    repeat (3) @(negedge clk);
    chk_val("rst_flags", {27'd0, grow, game_over, win, busy, done}, 32'd0);
    chk_val("rst_food", {16'd0, food_y, food_x}, {16'd0, 8'd5, 8'd5});
    rst = 1'b1;
    @(negedge clk);

    // Eat from reset: candidates ACE1 -> (1,12) rejected, 59C3 -> (3,9) accepted.
    snake3_eat();
    run_step(lat, g, b_ok);
    chk_val("eat_lat", 32'(lat), 32'd9);
    chk_val("eat_grow", 32'(g), 32'd1);
    chk_val("eat_busy", 32'(b_ok), 32'd1);
    chk_val("eat_food", {16'd0, food_y, food_x}, {16'd0, 8'd9, 8'd3});
    free_ok = (food_x < 8'(c_SX)) && (food_y < 8'(c_SY));
    for (int i = 0; i < 3; i++) begin
      if (snake_xy[i*16 +: 16] == {food_y, food_x}) free_ok = 1'b0;
    end
    chk_val("eat_food_free", 32'(free_ok), 32'd1);

    // Plain step, no eat, no collision.
    lengh = 16'd4;
    set_seg(3, 8'd2, 8'd5);
    run_step(lat, g, b_ok);
    chk_val("norm_lat", 32'(lat), 32'd5);
    chk_val("norm_flags", {30'd0, g, game_over}, 32'd0);
    chk_val("norm_food", {16'd0, food_y, food_x}, {16'd0, 8'd9, 8'd3});

    // Head (3,3) hits segment 3 of 5.
    lengh = 16'd5;
    set_seg(0, 8'd3, 8'd3);
    set_seg(1, 8'd2, 8'd3);
    set_seg(2, 8'd2, 8'd2);
    set_seg(3, 8'd3, 8'd3);
    set_seg(4, 8'd4, 8'd3);
    run_step(lat, g, b_ok);
    chk_val("self_lat", 32'(lat), 32'd5);
    chk_val("self_grow", 32'(g), 32'd0);
    chk_val("self_go", 32'(game_over), 32'd1);
    check_ignored("self_ignored");
    chk_val("self_go_hold", 32'(game_over), 32'd1);
    do_start();
    chk_val("start_clear", {16'd0, 7'd0, game_over, food_y, food_x}, {16'd0, 8'd0, 8'd5, 8'd5});

    // Walls: x = SIZE_X and y = 255.
    lengh = 16'd4;
    set_seg(0, 8'd10, 8'd3);
    run_step(lat, g, b_ok);
    chk_val("wallx_lat", 32'(lat), 32'd2);
    chk_val("wallx_res", {30'd0, game_over, g}, 32'd2);
    do_start();
    set_seg(0, 8'd0, 8'd255);
    run_step(lat, g, b_ok);
    chk_val("wally_lat", 32'(lat), 32'd2);
    chk_val("wally_res", {30'd0, game_over, g}, 32'd2);
    do_start();

    // Food eaten and self collision on the same step: no grow.
    lengh = 16'd3;
    set_seg(0, 8'd5, 8'd5);
    set_seg(1, 8'd4, 8'd5);
    set_seg(2, 8'd5, 8'd5);
    run_step(lat, g, b_ok);
    chk_val("eatcol_lat", 32'(lat), 32'd4);
    chk_val("eatcol_res", {30'd0, game_over, g}, 32'd2);
    chk_val("eatcol_food", {16'd0, food_y, food_x}, {16'd0, 8'd5, 8'd5});
    do_start();

    // Field full after this eat: win, grow, no placement.
    lengh = 16'd99;
    set_seg(0, 8'd5, 8'd5);
    for (int i = 1; i < 99; i++) set_seg(i, 8'd200, 8'd200);
    run_step(lat, g, b_ok);
    chk_val("win_lat", 32'(lat), 32'd100);
    chk_val("win_res", {29'd0, win, g, game_over}, 32'd6);
    chk_val("win_food", {16'd0, food_y, food_x}, {16'd0, 8'd5, 8'd5});
    check_ignored("win_ignored");
    do_start();
    chk_val("win_clear", 32'(win), 32'd0);

    // After start the LFSR is back at SEED, so placement repeats.
    snake3_eat();
    run_step(lat, g, b_ok);
    chk_val("eat2_lat", 32'(lat), 32'd9);
    chk_val("eat2_food", {16'd0, food_y, food_x}, {16'd0, 8'd9, 8'd3});

    // Asynchronous reset in the middle of a long scan.
    lengh = 16'd99;
    set_seg(0, 8'd1, 8'd1);
    for (int i = 1; i < 99; i++) set_seg(i, 8'd200, 8'd200);
    check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    repeat (10) @(negedge clk);
    chk_val("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_val("arst_flags", {27'd0, grow, game_over, win, busy, done}, 32'd0);
    chk_val("arst_food", {16'd0, food_y, food_x}, {16'd0, 8'd5, 8'd5});
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk_val("arst_quiet", 32'(seen), 32'd0);

    // start while in VERIFY (sixth cycle after check).
    snake3_eat();
    check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_val("vstart_state", {29'd0, busy, done, game_over}, 32'd0);
    chk_val("vstart_food", {16'd0, food_y, food_x}, {16'd0, 8'd5, 8'd5});
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk_val("vstart_nodone", 32'(seen), 32'd0);
    run_step(lat, g, b_ok);
    chk_val("vstart_seed_lat", 32'(lat), 32'd9);
    chk_val("vstart_seed_food", {16'd0, food_y, food_x}, {16'd0, 8'd9, 8'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
